lcd_page_arbiter: RTL and testbench
===================================

// Module: lcd_page_arbiter
// PURPOSE
//  Shares the single 2x16 character LCD between NREQ requesters (clock display, error
//  reporter, menu, etc.). Selects one requester's two text lines at a time and drives them
//  to the 128-bit line1/line2 inputs of the LCD driver.
//  Each grant is held for a minimum display time, then the display rotates round-robin
//  among active requesters. Sits between the application blocks and the LCD driver, in
//  the clk_400hz domain.
// PARAMETERS
//  NREQ        4    number of requesters (2..8)
//  HOLD_TICKS  800  minimum grant time in clk_400hz cycles (800 = 2 s); >= 1
//  CW          10   hold counter width; must satisfy 2**CW > HOLD_TICKS
// PORTS
//  clk_400hz  in   1         display clock, all logic on rising edge
//  rst        in   1         reset, asynchronous, active-high
//  req        in   NREQ      req[i]=1: requester i wants the display (level, not pulse)
//  req_line1  in   NREQ*128  requester i top line at [i*128 +: 128], char0 in MSB byte
//  req_line2  in   NREQ*128  requester i bottom line, same packing
//  line1      out  128       text to LCD driver, top line
//  line2      out  128       text to LCD driver, bottom line
//  grant      out  NREQ      one-hot current owner; all-zero when idle
//  busy       out  1         1 when any grant is active
//  released   out  NREQ      one-cycle pulse on bit i when requester i loses grant
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, busy=0, released=0, rr_ptr=NREQ-1,
//   hold counter=0, line1=line2={16{8'h20}} (all spaces).
//  States: IDLE, HOLD, SHARE. All outputs are registered.
//  IDLE: line1/line2 = spaces. If req!=0, pick winner w = first set bit searching
//   rr_ptr+1, rr_ptr+2, ... mod NREQ. Next cycle: grant=onehot(w), busy=1, rr_ptr=w,
//   cnt=HOLD_TICKS-1, state=HOLD. Grant latency is exactly 1 cycle after req is seen.
//  Text path: in HOLD/SHARE, every cycle line1/line2 <= owner's req_line1/req_line2
//   (1-cycle lag). The owner may therefore update its text live while it holds grant.
//  HOLD: cnt decrements once per cycle. When cnt==0 and owner still requests, go to SHARE.
//  SHARE: if any other req bit is set, switch to the round-robin winner among the others
//   (search from owner+1). The new grant starts its HOLD with cnt=HOLD_TICKS-1. Otherwise
//   the owner keeps the display indefinitely.
//  Owner withdraws (req[owner]=0) in HOLD or SHARE: it releases immediately, even mid-hold.
//   Same cycle, arbitrate among the remaining reqs. Next cycle, either a new grant (HOLD)
//   or IDLE with grant=0, busy=0, and lines=spaces.
//  released[i] pulses for exactly one cycle, aligned with the cycle grant[i] falls.
//   Switch-over is a single cycle: old bit low, new bit high, and released of the old
//   owner high, all in the same cycle. There is no idle gap between owners.
//  Simultaneous requests are resolved by round robin only; there is no fixed priority.
//   A requester never wins twice in a row while another requests in SHARE.
//  Owner withdraws exactly on the cycle cnt reaches 0: the withdraw rule wins.
//  grant is always one-hot or zero. busy == |grant.
//  Illegal state encodings recover to IDLE.
// TESTING (NREQ=4, HOLD_TICKS=4)
//  1. Reset with req=4'b0010 held: line1/line2 are spaces and grant=0 while rst is high.
//     After release, grant=4'b0010 one cycle later, and line1 equals req_line1[255:128]
//     on the following cycle.
//  2. req=4'b1111 from IDLE with rr_ptr=3: grants in order 0001,0010,0100,1000,0001. Each
//     owner holds exactly 4 cycles; released pulses on each change-over.
//  3. Only req[2] held: grant stays 4'b0100 indefinitely. Changing req_line2[2] to "ERR"
//     appears on line2 one cycle later.
//  4. Owner 1 drops req on its 2nd hold cycle with req[3]=1: next cycle grant=4'b1000,
//     released=4'b0010, and the new hold lasts a full 4 cycles.
//  5. Owner drops req with no other requests: next cycle grant=0, busy=0, lines=spaces,
//     released pulses one cycle.
//  6. Assert rst mid-HOLD: outputs take reset values asynchronously. After release, the
//     first grant follows RR from rr_ptr=3.

Source files
------------

// File: rtl/lcd_page_arbiter.sv
// lcd_page_arbiter: round-robin sharing of one 2x16 LCD among NREQ requesters,
// with a minimum hold time per grant and immediate release on withdraw.
module lcd_page_arbiter #(
    parameter int NREQ       = 4,
    parameter int HOLD_TICKS = 800,
    parameter int CW         = 10
) (
    input  logic                 clk_400hz,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*128-1:0]  req_line1,
    input  logic [NREQ*128-1:0]  req_line2,
    output logic [127:0]         line1,
    output logic [127:0]         line2,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [NREQ-1:0]      released
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [127:0] SPACES = {16{8'h20}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_SHARE = 2'd2} state_t;

    state_t          r_state, w_state;
    logic [NREQ-1:0] r_grant, w_grant, r_released, w_cand;
    logic [PW-1:0]   r_rr, w_rr, w_win;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [127:0]    r_line1, r_line2;
    logic            r_busy, w_found, w_line_en;

    // r_rr always names the current owner, so searching from r_rr+1 with the
    // owner masked out serves both fresh arbitration and change-over
    always_comb begin
        w_cand  = req & ~r_grant;
        w_found = 1'b0;
        w_win   = r_rr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && w_cand[(int'(r_rr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_rr    = r_rr;
        w_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_HOLD;
                    w_grant = NREQ'(1) << w_win;
                    w_rr    = w_win;
                    w_cnt   = CW'(HOLD_TICKS - 1);
                end
            end
            S_HOLD, S_SHARE: begin
                // withdraw, hold expiry and sharing all resolve in the same cycle
                if (!req[r_rr] || r_state == S_SHARE || r_cnt == '0) begin
                    if (w_found) begin
                        w_state = S_HOLD;
                        w_grant = NREQ'(1) << w_win;
                        w_rr    = w_win;
                        w_cnt   = CW'(HOLD_TICKS - 1);
                    end else if (!req[r_rr]) begin
                        w_state = S_IDLE;
                        w_grant = '0;
                    end else begin
                        w_state = S_SHARE;
                    end
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = '0;
            end
        endcase
    end

    assign w_line_en = (r_state == S_HOLD || r_state == S_SHARE) && w_state != S_IDLE;

    always_ff @(posedge clk_400hz or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_released <= '0;
            r_rr       <= PW'(NREQ - 1);
            r_cnt      <= '0;
            r_line1    <= SPACES;
            r_line2    <= SPACES;
        end else begin
            r_state    <= w_state;
            r_grant    <= w_grant;
            r_busy     <= |w_grant;
            r_released <= r_grant & ~w_grant;
            r_rr       <= w_rr;
            r_cnt      <= w_cnt;
            r_line1    <= w_line_en ? req_line1[int'(r_rr)*128 +: 128] : SPACES;
            r_line2    <= w_line_en ? req_line2[int'(r_rr)*128 +: 128] : SPACES;
        end
    end

    assign line1    = r_line1;
    assign line2    = r_line2;
    assign grant    = r_grant;
    assign busy     = r_busy;
    assign released = r_released;
endmodule

// File: tb/tb_lcd_page_arbiter.sv
// tb_lcd_page_arbiter: directed scenarios for lcd_page_arbiter with NREQ=4,
// HOLD_TICKS=4; inputs change and outputs are sampled on the falling edge.
module tb_lcd_page_arbiter;
    localparam logic [127:0] SP  = {16{8'h20}};
    localparam logic [127:0] ERR = {8'h45, 8'h52, 8'h52, {13{8'h20}}};

    logic         clk_400hz = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [511:0] req_line1, req_line2;
    logic [127:0] line1, line2;
    logic [3:0]   grant, released;
    logic         busy;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk_400hz = ~clk_400hz;

    lcd_page_arbiter #(.NREQ(4), .HOLD_TICKS(4), .CW(3)) dut (
        .clk_400hz(clk_400hz), .rst(rst), .req(req),
        .req_line1(req_line1), .req_line2(req_line2),
        .line1(line1), .line2(line2), .grant(grant), .busy(busy), .released(released)
    );

    task automatic tick;
        @(negedge clk_400hz);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b0010;
        tick;
        tick;
        n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", grant); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (released !== 4'b0000) begin n_err++; $display("FAIL reset_released got %b want 0000", released); end
        n_vec++; if (line1 !== SP) begin n_err++; $display("FAIL reset_line1 got %h want %h", line1, SP); end
        n_vec++; if (line2 !== SP) begin n_err++; $display("FAIL reset_line2 got %h want %h", line2, SP); end
        rst = 1'b0;
        tick;
        n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL first_grant got %b want 0010", grant); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy got %b want 1", busy); end
        n_vec++; if (line1 !== SP) begin n_err++; $display("FAIL first_line1_lag got %h want %h", line1, SP); end
        tick;
        n_vec++; if (line1 !== {16{8'h42}}) begin n_err++; $display("FAIL owner1_line1 got %h want %h", line1, {16{8'h42}}); end
        n_vec++; if (line2 !== {16{8'h62}}) begin n_err++; $display("FAIL owner1_line2 got %h want %h", line2, {16{8'h62}}); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g, exp_r;
        do_reset;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                exp_g = 4'b0001 << (g % 4);
                exp_r = (c == 0 && g > 0) ? 4'b0001 << ((g - 1) % 4) : 4'b0000;
                n_vec++; if (grant !== exp_g) begin n_err++; $display("FAIL rr_grant g=%0d c=%0d got %b want %b", g, c, grant, exp_g); end
                n_vec++; if (released !== exp_r) begin n_err++; $display("FAIL rr_released g=%0d c=%0d got %b want %b", g, c, released, exp_r); end
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rr_busy g=%0d c=%0d got %b want 1", g, c, busy); end
            end
        end
    endtask

    task automatic test_single_owner;
        req = 4'b0100;
        tick;
        n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", grant); end
        n_vec++; if (released !== 4'b0001) begin n_err++; $display("FAIL single_released got %b want 0001", released); end
        for (int c = 0; c < 10; c++) begin
            tick;
            n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_hold c=%0d got %b want 0100", c, grant); end
            n_vec++; if (released !== 4'b0000) begin n_err++; $display("FAIL single_norel c=%0d got %b want 0000", c, released); end
        end
        n_vec++; if (line1 !== {16{8'h43}}) begin n_err++; $display("FAIL single_line1 got %h want %h", line1, {16{8'h43}}); end
        req_line2[256 +: 128] = ERR;
        tick;
        n_vec++; if (line2 !== ERR) begin n_err++; $display("FAIL live_text got %h want %h", line2, ERR); end
    endtask

    task automatic test_withdraw_switch;
        do_reset;
        req = 4'b0010;
        tick;
        n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL wd_first got %b want 0010", grant); end
        req = 4'b1001;
        tick;
        n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wd_grant got %b want 1000", grant); end
        n_vec++; if (released !== 4'b0010) begin n_err++; $display("FAIL wd_released got %b want 0010", released); end
        for (int c = 1; c < 4; c++) begin
            tick;
            n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL wd_hold c=%0d got %b want 1000", c, grant); end
            n_vec++; if (released !== 4'b0000) begin n_err++; $display("FAIL wd_norel c=%0d got %b want 0000", c, released); end
        end
        tick;
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL wd_next got %b want 0001", grant); end
        n_vec++; if (released !== 4'b1000) begin n_err++; $display("FAIL wd_next_rel got %b want 1000", released); end
    endtask

    task automatic test_withdraw_idle;
        req = 4'b0000;
        tick;
        n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL idle_grant got %b want 0000", grant); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
        n_vec++; if (line1 !== SP) begin n_err++; $display("FAIL idle_line1 got %h want %h", line1, SP); end
        n_vec++; if (line2 !== SP) begin n_err++; $display("FAIL idle_line2 got %h want %h", line2, SP); end
        n_vec++; if (released !== 4'b0001) begin n_err++; $display("FAIL idle_released got %b want 0001", released); end
        tick;
        n_vec++; if (released !== 4'b0000) begin n_err++; $display("FAIL idle_pulse_len got %b want 0000", released); end
    endtask

    task automatic test_async_reset;
        req = 4'b0100;
        tick;
        n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL ar_grant got %b want 0100", grant); end
        tick;
        n_vec++; if (line1 !== {16{8'h43}}) begin n_err++; $display("FAIL ar_line1 got %h want %h", line1, {16{8'h43}}); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL ar_async_grant got %b want 0000", grant); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_async_busy got %b want 0", busy); end
        n_vec++; if (line1 !== SP) begin n_err++; $display("FAIL ar_async_line1 got %h want %h", line1, SP); end
        n_vec++; if (line2 !== SP) begin n_err++; $display("FAIL ar_async_line2 got %h want %h", line2, SP); end
        req = 4'b1111;
        tick;
        rst = 1'b0;
        tick;
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL ar_rr_restart got %b want 0001", grant); end
        n_vec++; if (released !== 4'b0000) begin n_err++; $display("FAIL ar_released got %b want 0000", released); end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_line1[i*128 +: 128] = {16{8'h41 + 8'(i)}};
            req_line2[i*128 +: 128] = {16{8'h61 + 8'(i)}};
        end
        test_reset;
        test_round_robin;
        test_single_owner;
        test_withdraw_switch;
        test_withdraw_idle;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
